// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder bit per clock, LSB first, with a registered carry.
// A start in IDLE captures the operands; the result is presented with a one-cycle done pulse.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             C
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;

  logic a_bit, b_bit, sum_bit, carry_out;

  // Single full adder working on the bit selected by the counter.
  assign a_bit     = a_q[cnt_q];
  assign b_bit     = b_q[cnt_q];
  assign sum_bit   = a_bit ^ b_bit ^ carry_q;
  assign carry_out = (a_bit & b_bit) | (carry_q & (a_bit ^ b_bit));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    c_d     = c_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          carry_d = Cin;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Sum bits enter at the MSB so bit 0 lands at position 0 after WIDTH shifts.
        sum_d   = {sum_bit, sum_q[WIDTH-1:1]};
        carry_d = carry_out;
        if (cnt_q == LAST_IDX) begin
          cnt_d   = '0;
          c_d     = carry_out;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
    end
  end

  assign busy = (state_q == ST_SHIFT);
  assign done = (state_q == ST_DONE);
  assign S    = sum_q;
  assign C    = c_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: expected sums are queued when a start is accepted
// and checked against S/C and the done cycle when the done pulse appears.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] A, B;
  logic         Cin;
  logic         busy, done;
  logic [W-1:0] S;
  logic         C;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    int           due;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .busy  (busy),
    .done  (done),
    .S     (S),
    .C     (C)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Queue the golden result; the start is accepted on the coming edge, done is seen W edges later.
  task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input int due);
    logic [W:0] t;
    exp_t e;
    t     = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    e.s   = t[W-1:0];
    e.c   = t[W];
    e.due = due;
    exp_q.push_back(e);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    @(negedge clk);
    A = a; B = b; Cin = cin; start = 1'b1;
    push_exp(a, b, cin, cyc + 1 + W);
    @(negedge clk);
    start = 1'b0;
    A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
    repeat (W + 2) @(negedge clk);
  endtask

  // Output monitor
  always @(negedge clk) begin
    if (!rst) begin
      check_eq("busy_done_exclusive", {63'd0, busy & done}, 64'd0);
      if (exp_q.size() == 0) begin
        check_eq("unexpected_done", {63'd0, done}, 64'd0);
      end else if (done) begin
        mon_e = exp_q.pop_front();
        $display("txn S=%02h C=%0d exp S=%02h C=%0d cycle=%0d", S, C, mon_e.s, mon_e.c, cyc);
        check_eq("sum", 64'(S), 64'(mon_e.s));
        check_eq("carry", {63'd0, C}, {63'd0, mon_e.c});
        check_eq("done_cycle", 64'(cyc), 64'(mon_e.due));
      end else if (cyc > exp_q[0].due) begin
        check_eq("done_missing", 64'(cyc), 64'(exp_q[0].due));
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_done", {63'd0, done}, 64'd0);
    check_eq("rst_S", 64'(S), 64'd0);
    check_eq("rst_C", {63'd0, C}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors
    run_op(8'h00, 8'h00, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0);
    run_op(8'hA5, 8'h5A, 1'b1);
    check_eq("hold_S", 64'(S), 64'h00);
    check_eq("hold_C", {63'd0, C}, 64'd1);

    // Second start and operand change mid-SHIFT must be ignored.
    @(negedge clk);
    A = 8'h3C; B = 8'h42; Cin = 1'b0; start = 1'b1;
    push_exp(8'h3C, 8'h42, 1'b0, cyc + 1 + W);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; A = 8'hFF; B = 8'hFF; Cin = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (W + 4) @(negedge clk);
    check_eq("restart_S_hold", 64'(S), 64'h7E);

    // Reset mid-SHIFT aborts with no done pulse.
    @(negedge clk);
    A = 8'h80; B = 8'h80; Cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("pre_rst_busy", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    #1;
    check_eq("abort_busy", {63'd0, busy}, 64'd0);
    check_eq("abort_done", {63'd0, done}, 64'd0);
    check_eq("abort_S", 64'(S), 64'd0);
    check_eq("abort_C", {63'd0, C}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (W + 6) @(negedge clk);

    // First start after reset is accepted normally.
    run_op(8'h12, 8'h34, 1'b1);

    // Back-to-back with start held high: one result every W+2 cycles.
    @(negedge clk);
    A = W'($urandom); B = W'($urandom); Cin = 1'($urandom); start = 1'b1;
    push_exp(A, B, Cin, cyc + 1 + W);
    for (int i = 1; i < 1000; i++) begin
      @(negedge clk);
      A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
      push_exp(A, B, Cin, cyc + 2 * W + 2);
      repeat (W + 1) @(negedge clk);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (2 * W + 4) @(negedge clk);

    check_eq("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: the reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin one addition.
REQ-005 The block SHALL have port A, input, WIDTH bits: operand A.
REQ-006 The block SHALL have port B, input, WIDTH bits: operand B.
REQ-007 The block SHALL have port Cin, input, 1 bit: carry-in.
REQ-008 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking the result valid.
REQ-010 The block SHALL have port S, output, WIDTH bits: the sum.
REQ-011 The block SHALL have port C, output, 1 bit: the carry-out.

Function
REQ-012 The block SHALL compute {C,S} = A + B + Cin bit-serially, LSB first, one bit per clock through a single 1-bit full adder and a registered carry.
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-014 IDLE SHALL behave as follows: on an edge with start=1, capture A, B and Cin into internal registers, clear the bit counter, and go to SHIFT; with start=0, remain in IDLE.
REQ-015 SHIFT SHALL behave as follows: each edge computes the sum bit for the current counter index, shifts it into the result register, updates the carry register and increments the counter.
REQ-016 SHIFT SHALL move to DONE on the edge that processes bit WIDTH-1.
REQ-017 DONE SHALL last exactly one cycle and unconditionally go to IDLE.
REQ-018 Latency: if start is sampled at edge k, done SHALL be high during the cycle after edge k+WIDTH and low again after edge k+WIDTH+1.
REQ-019 busy SHALL be high exactly while the state is SHIFT.
REQ-020 done SHALL be high exactly while the state is DONE.
REQ-021 busy and done SHALL never be high simultaneously.
REQ-022 S and C SHALL be driven from registers and SHALL be valid from the DONE cycle onward.
REQ-023 S and C SHALL hold their values until the next accepted start, then may change freely while busy.
REQ-024 start SHALL be ignored in SHIFT and in DONE; no queuing and no restart.
REQ-025 A, B and Cin SHALL be sampled only at the accepting edge; changes afterwards SHALL NOT affect the result.
REQ-026 Back-to-back operation: start held high SHALL be accepted on the first IDLE edge after DONE, giving a period of WIDTH+2 cycles per operation.
REQ-027 Overflow SHALL appear only on C; S SHALL wrap modulo 2^WIDTH.
REQ-028 The counter SHALL be $clog2(WIDTH) bits wide and SHALL never index outside 0..WIDTH-1.

Reset
REQ-029 While rst=1, regardless of clk, the block SHALL be in state IDLE with busy=0, done=0, S=0, C=0, and the counter, carry register and operand registers all 0.
REQ-030 Reset asserted mid-SHIFT SHALL abort the operation with no done pulse.
REQ-031 After reset deasserts, the first edge with start=1 SHALL be accepted normally.

Verification
REQ-032 The bench SHALL apply A=8'h00, B=8'h00, Cin=0 with a start pulse and SHALL see S=8'h00 and C=0 with done 8 edges after the start edge plus one.
REQ-033 The bench SHALL apply A=8'hFF, B=8'h01, Cin=0 and SHALL see S=8'h00, C=1.
REQ-034 The bench SHALL apply A=8'hA5, B=8'h5A, Cin=1 and SHALL see S=8'h00, C=1.
REQ-035 The bench SHALL apply A=8'h3C, B=8'h42, Cin=0, then pulse start again and change A/B mid-SHIFT, and SHALL see S=8'h7E, C=0 and exactly one done pulse.
REQ-036 The bench SHALL assert rst for 1 cycle during SHIFT of A=8'h80, B=8'h80, and SHALL see busy=0, done=0, S=0, C=0 immediately and no done pulse afterwards.
REQ-037 The bench SHALL hold start=1 and drive 1000 random A/B/Cin vectors, and every result SHALL match a golden A+B+Cin model, with done exactly every 10 cycles.
